// File: rtl/ppu_multi_sync_ctrl.sv
// Frame-sync controller for NUM_CH independent DMA / shadow-buffer channels.
// Each channel launches a DMA from a CPU-written source address and tracks its
// completion. At vblank every channel holding a finished DMA gets one sync
// command, and a ready IRQ follows once that channel's shadow copy is done.
// Unfinished syncs are retried on the next vblank, stuck DMAs are aborted by a
// per-channel watchdog, and empty frames / sync overruns are counted.
module ppu_multi_sync_ctrl #(
  parameter int NUM_CH      = 3,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_FRM = 4,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vblank_start,
  input  logic                     vblank_end_soon,
  input  logic                     rowram_swap,
  output logic                     rowram_swap_disp,
  output logic                     sync_active,
  input  logic [NUM_CH*ADDR_W-1:0] src_rddata,
  input  logic [NUM_CH-1:0]        src_update_avail,
  output logic [NUM_CH-1:0]        src_read_rst,
  output logic [NUM_CH*ADDR_W-1:0] dma_src_addr,
  output logic [NUM_CH-1:0]        dma_start,
  input  logic [NUM_CH-1:0]        dma_finish,
  output logic [NUM_CH-1:0]        ch_sync,
  input  logic [NUM_CH-1:0]        ch_sync_done,
  output logic [NUM_CH-1:0]        dma_rdy_irq,
  output logic [NUM_CH-1:0]        dma_timeout_irq,
  output logic [CNT_W-1:0]         dropped_frames,
  output logic [CNT_W-1:0]         sync_overruns
);

  // Watchdog holds 0..TIMEOUT_FRM-1; reaching TIMEOUT_FRM means abort instead.
  localparam int WD_W = (TIMEOUT_FRM > 1) ? $clog2(TIMEOUT_FRM) : 1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_FRM - 1);
  localparam logic [WD_W-1:0]  WD_ONE  = WD_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DISP = 2'd1,
    ST_SYNC = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic              sync_enter;
  logic              sync_exit;
  logic              drop_frame;

  // Per-channel status flags
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] ready;
  logic [NUM_CH-1:0] syncing;
  logic [WD_W-1:0]   wdog [NUM_CH];

  // Per-channel events of the current cycle
  logic [NUM_CH-1:0] launch;
  logic [NUM_CH-1:0] fin_ok;
  logic [NUM_CH-1:0] done_ok;
  logic [NUM_CH-1:0] wd_tick;
  logic [NUM_CH-1:0] wd_expire;
  logic [NUM_CH-1:0] retry;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  assign rowram_swap_disp = rowram_swap & (state == ST_DISP);
  assign sync_active      = (state == ST_SYNC);
  assign src_read_rst     = launch;

  // Frame state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Frame FSM transitions and the strobes marking each interesting edge
  always_comb begin
    state_nxt  = state;
    sync_enter = 1'b0;
    sync_exit  = 1'b0;
    drop_frame = 1'b0;
    case (state)
      ST_IDLE: begin
        if (vblank_end_soon) state_nxt = ST_DISP;
      end
      ST_DISP: begin
        if (vblank_start) begin
          if (|ready) begin
            state_nxt  = ST_SYNC;
            sync_enter = 1'b1;
          end else begin
            state_nxt  = ST_IDLE;
            drop_frame = 1'b1;
          end
        end
      end
      ST_SYNC: begin
        if (vblank_end_soon) begin
          state_nxt = ST_DISP;
          sync_exit = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Per-channel event decode; a finish landing on the timeout cycle beats the abort
  always_comb begin
    launch    = src_update_avail & ~busy & ~ready & ~syncing;
    fin_ok    = dma_finish & busy;
    done_ok   = (state == ST_SYNC) ? (ch_sync_done & syncing) : '0;
    wd_tick   = vblank_start ? busy : '0;
    retry     = sync_exit ? (syncing & ~done_ok) : '0;
    wd_expire = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wd_expire[i] = wd_tick[i] & (wdog[i] == WD_LAST) & ~fin_ok[i];
    end
  end

  // Channel flags and single-cycle command / IRQ pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy            <= '0;
      ready           <= '0;
      syncing         <= '0;
      dma_start       <= '0;
      ch_sync         <= '0;
      dma_rdy_irq     <= '0;
      dma_timeout_irq <= '0;
    end else begin
      busy            <= (busy & ~fin_ok & ~wd_expire) | launch;
      ready           <= (sync_enter ? '0 : ready) | fin_ok | retry;
      syncing         <= (syncing & ~done_ok & ~retry) | (sync_enter ? ready : '0);
      dma_start       <= launch;
      ch_sync         <= sync_enter ? ready : '0;
      dma_rdy_irq     <= done_ok;
      dma_timeout_irq <= wd_expire;
    end
  end

  // Watchdog: counts vblanks while a DMA is in flight, cleared on any DMA end or launch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) wdog[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (launch[i] | fin_ok[i] | wd_expire[i]) wdog[i] <= '0;
        else if (wd_tick[i])                     wdog[i] <= wdog[i] + WD_ONE;
      end
    end
  end

  // DMA source address captured from the PIO data when the launch is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dma_src_addr <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (launch[i]) dma_src_addr[i*ADDR_W +: ADDR_W] <= src_rddata[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Saturating frame statistics; an overrun counts once per SYNC period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dropped_frames <= '0;
      sync_overruns  <= '0;
    end else begin
      if (drop_frame) dropped_frames <= sat_inc(dropped_frames);
      if (|retry)     sync_overruns  <= sat_inc(sync_overruns);
    end
  end

endmodule

// File: tb/tb_ppu_multi_sync_ctrl.sv
// Bench for ppu_multi_sync_ctrl: scenario tasks drive the frame/channel events,
// push expected pulses into queues, and a negedge monitor pops them as the DUT
// emits dma_start, ch_sync, dma_rdy_irq and dma_timeout_irq.
module tb_ppu_multi_sync_ctrl;

  localparam int NCH = 3;
  localparam int AW  = 32;
  localparam int TO  = 2;
  localparam int CW  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              vblank_start, vblank_end_soon, rowram_swap;
  logic              rowram_swap_disp, sync_active;
  logic [NCH*AW-1:0] src_rddata;
  logic [NCH-1:0]    src_update_avail, src_read_rst;
  logic [NCH*AW-1:0] dma_src_addr;
  logic [NCH-1:0]    dma_start, dma_finish, ch_sync, ch_sync_done;
  logic [NCH-1:0]    dma_rdy_irq, dma_timeout_irq;
  logic [CW-1:0]     dropped_frames, sync_overruns;

  int tests_run = 0;
  int fails     = 0;

  typedef struct packed {
    logic [NCH-1:0]    m;
    logic [NCH*AW-1:0] a;
  } start_t;

  start_t         start_q[$];
  logic [NCH-1:0] sync_q[$];
  logic [NCH-1:0] rdy_q[$];
  logic [NCH-1:0] to_q[$];

  start_t         mon_s;
  logic [NCH-1:0] mon_e;
  logic [NCH*AW-1:0] mon_am;

  ppu_multi_sync_ctrl #(
    .NUM_CH(NCH), .ADDR_W(AW), .TIMEOUT_FRM(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .vblank_start(vblank_start), .vblank_end_soon(vblank_end_soon),
    .rowram_swap(rowram_swap), .rowram_swap_disp(rowram_swap_disp),
    .sync_active(sync_active),
    .src_rddata(src_rddata), .src_update_avail(src_update_avail),
    .src_read_rst(src_read_rst), .dma_src_addr(dma_src_addr),
    .dma_start(dma_start), .dma_finish(dma_finish),
    .ch_sync(ch_sync), .ch_sync_done(ch_sync_done),
    .dma_rdy_irq(dma_rdy_irq), .dma_timeout_irq(dma_timeout_irq),
    .dropped_frames(dropped_frames), .sync_overruns(sync_overruns)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  // Scoreboard monitor: every non-zero pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (dma_start !== '0) begin
      tests_run++;
      if (start_q.size() == 0) begin
        fails++;
        $display("FAIL dma_start_unexpected: got %b, required no pulse", dma_start);
      end else begin
        mon_s  = start_q.pop_front();
        mon_am = '0;
        for (int i = 0; i < NCH; i++) if (mon_s.m[i]) mon_am[i*AW +: AW] = '1;
        if (dma_start !== mon_s.m || (dma_src_addr & mon_am) !== (mon_s.a & mon_am)) begin
          fails++;
          $display("FAIL dma_start: got %b addr %h, required %b addr %h",
                   dma_start, dma_src_addr & mon_am, mon_s.m, mon_s.a & mon_am);
        end
      end
    end
    if (ch_sync !== '0) begin
      tests_run++;
      if (sync_q.size() == 0) begin
        fails++;
        $display("FAIL ch_sync_unexpected: got %b, required no pulse", ch_sync);
      end else begin
        mon_e = sync_q.pop_front();
        if (ch_sync !== mon_e) begin
          fails++;
          $display("FAIL ch_sync: got %b, required %b", ch_sync, mon_e);
        end
      end
    end
    if (dma_rdy_irq !== '0) begin
      tests_run++;
      if (rdy_q.size() == 0) begin
        fails++;
        $display("FAIL dma_rdy_irq_unexpected: got %b, required no pulse", dma_rdy_irq);
      end else begin
        mon_e = rdy_q.pop_front();
        if (dma_rdy_irq !== mon_e) begin
          fails++;
          $display("FAIL dma_rdy_irq: got %b, required %b", dma_rdy_irq, mon_e);
        end
      end
    end
    if (dma_timeout_irq !== '0) begin
      tests_run++;
      if (to_q.size() == 0) begin
        fails++;
        $display("FAIL dma_timeout_irq_unexpected: got %b, required no pulse", dma_timeout_irq);
      end else begin
        mon_e = to_q.pop_front();
        if (dma_timeout_irq !== mon_e) begin
          fails++;
          $display("FAIL dma_timeout_irq: got %b, required %b", dma_timeout_irq, mon_e);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic go_disp();
    vblank_end_soon = 1'b1;
    tick(1);
    vblank_end_soon = 1'b0;
  endtask

  task automatic pulse_vbs();
    vblank_start = 1'b1;
    tick(1);
    vblank_start = 1'b0;
  endtask

  task automatic pulse_finish(input logic [NCH-1:0] m);
    dma_finish = m;
    tick(1);
    dma_finish = '0;
  endtask

  task automatic pulse_done(input logic [NCH-1:0] m);
    ch_sync_done = m;
    tick(1);
    ch_sync_done = '0;
  endtask

  // Launch the channels in m; the caller has already loaded src_rddata
  task automatic launch_ch(input logic [NCH-1:0] m, input string nm);
    start_t s;
    src_update_avail = m;
    #1;
    tests_run++;
    if (src_read_rst !== m) begin
      fails++;
      $display("FAIL %s_read_rst: got %b, required %b", nm, src_read_rst, m);
    end
    s.m = m;
    s.a = src_rddata;
    start_q.push_back(s);
    tick(1);
    src_update_avail = '0;
  endtask

  task automatic check_drained(input string nm);
    tests_run++;
    if (start_q.size() + sync_q.size() + rdy_q.size() + to_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drained: got %0d/%0d/%0d/%0d pending start/sync/rdy/timeout, required 0",
               nm, start_q.size(), sync_q.size(), rdy_q.size(), to_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    tests_run++;
    if ({sync_active, rowram_swap_disp, dma_start, ch_sync, dma_rdy_irq, dma_timeout_irq} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got sa=%b rsd=%b st=%b cs=%b ri=%b ti=%b, required all 0",
               sync_active, rowram_swap_disp, dma_start, ch_sync, dma_rdy_irq, dma_timeout_irq);
    end
    tests_run++;
    if (dma_src_addr !== '0 || dropped_frames !== '0 || sync_overruns !== '0) begin
      fails++;
      $display("FAIL reset_regs: got addr=%h df=%0d so=%0d, required 0", dma_src_addr, dropped_frames, sync_overruns);
    end
    rst = 1'b0;
    tick(1);
    go_disp();
    tests_run++;
    if (rowram_swap_disp !== 1'b1 || sync_active !== 1'b0) begin
      fails++;
      $display("FAIL disp_entry: got rsd=%b sa=%b, required rsd=1 sa=0", rowram_swap_disp, sync_active);
    end
  endtask

  task automatic test_launch();
    src_rddata = {32'h0000_3333, 32'h0000_4000, 32'h0000_1111};
    launch_ch(3'b010, "launch1");
    tests_run++;
    if (dma_src_addr[AW +: AW] !== 32'h0000_4000 || dma_start !== 3'b010) begin
      fails++;
      $display("FAIL launch1_addr: got addr=%h start=%b, required 00004000 010", dma_src_addr[AW +: AW], dma_start);
    end
    // A new request on a busy channel stays pending
    src_update_avail = 3'b010;
    #1;
    tests_run++;
    if (src_read_rst !== 3'b000) begin
      fails++;
      $display("FAIL busy_no_ack: got %b, required 000", src_read_rst);
    end
    tick(1);
    src_update_avail = '0;
    tick(1);
    check_drained("launch");
    do_reset();
  endtask

  task automatic test_sync();
    go_disp();
    src_rddata = {32'h0000_3000, 32'h0, 32'h0000_1000};
    launch_ch(3'b101, "launch02");
    pulse_finish(3'b101);
    sync_q.push_back(3'b101);
    pulse_vbs();
    tests_run++;
    if (sync_active !== 1'b1 || rowram_swap_disp !== 1'b0) begin
      fails++;
      $display("FAIL sync_entry: got sa=%b rsd=%b, required sa=1 rsd=0", sync_active, rowram_swap_disp);
    end
    rdy_q.push_back(3'b001);
    pulse_done(3'b001);
    tick(1);
    rdy_q.push_back(3'b100);
    pulse_done(3'b110);
    go_disp();
    tick(1);
    tests_run++;
    if (sync_overruns !== 4'd0 || sync_active !== 1'b0) begin
      fails++;
      $display("FAIL sync_clean_exit: got so=%0d sa=%b, required so=0 sa=0", sync_overruns, sync_active);
    end
    check_drained("sync");
  endtask

  task automatic test_overrun();
    src_rddata = {32'h0000_2222, 32'h0, 32'h0};
    launch_ch(3'b100, "launch2");
    pulse_finish(3'b100);
    sync_q.push_back(3'b100);
    pulse_vbs();
    tick(2);
    go_disp();
    tests_run++;
    if (sync_overruns !== 4'd1) begin
      fails++;
      $display("FAIL overrun_count: got %0d, required 1", sync_overruns);
    end
    // Channel 2 is ready again for retry, so a new address is not taken
    src_update_avail = 3'b100;
    #1;
    tests_run++;
    if (src_read_rst !== 3'b000) begin
      fails++;
      $display("FAIL retry_no_ack: got %b, required 000", src_read_rst);
    end
    src_update_avail = '0;
    sync_q.push_back(3'b100);
    pulse_vbs();
    rdy_q.push_back(3'b100);
    pulse_done(3'b100);
    go_disp();
    tick(1);
    tests_run++;
    if (sync_overruns !== 4'd1) begin
      fails++;
      $display("FAIL overrun_hold: got %0d, required 1", sync_overruns);
    end
    check_drained("overrun");
  endtask

  task automatic test_dropped();
    for (int k = 1; k <= 17; k++) begin
      pulse_vbs();
      tests_run++;
      if (dropped_frames !== CW'((k > 15) ? 15 : k) || rowram_swap_disp !== 1'b0 || sync_active !== 1'b0) begin
        fails++;
        $display("FAIL dropped_%0d: got df=%0d rsd=%b sa=%b, required df=%0d rsd=0 sa=0",
                 k, dropped_frames, rowram_swap_disp, sync_active, (k > 15) ? 15 : k);
      end
      if (k == 1) begin
        pulse_vbs();
        tests_run++;
        if (dropped_frames !== 4'd1) begin
          fails++;
          $display("FAIL idle_vbs_ignored: got df=%0d, required 1", dropped_frames);
        end
      end
      go_disp();
    end
    vblank_end_soon = 1'b1;
    tick(1);
    vblank_end_soon = 1'b0;
    tests_run++;
    if (rowram_swap_disp !== 1'b1) begin
      fails++;
      $display("FAIL disp_ves_ignored: got rsd=%b, required 1", rowram_swap_disp);
    end
    check_drained("dropped");
  endtask

  task automatic test_watchdog();
    do_reset();
    go_disp();
    src_rddata = {32'h0, 32'h0000_5000, 32'h0};
    launch_ch(3'b010, "wd_launch");
    pulse_vbs();
    go_disp();
    to_q.push_back(3'b010);
    pulse_vbs();
    tick(1);
    src_rddata = {32'h0, 32'h0000_6000, 32'h0};
    launch_ch(3'b010, "wd_relaunch");
    pulse_vbs();
    go_disp();
    vblank_start = 1'b1;
    dma_finish   = 3'b010;
    tick(1);
    vblank_start = 1'b0;
    dma_finish   = '0;
    tick(1);
    src_update_avail = 3'b010;
    #1;
    tests_run++;
    if (src_read_rst !== 3'b000) begin
      fails++;
      $display("FAIL wd_finish_ready: got %b, required 000", src_read_rst);
    end
    src_update_avail = '0;
    go_disp();
    sync_q.push_back(3'b010);
    pulse_vbs();
    rdy_q.push_back(3'b010);
    pulse_done(3'b010);
    go_disp();
    tick(1);
    tests_run++;
    if (dropped_frames !== 4'd3 || sync_overruns !== 4'd0) begin
      fails++;
      $display("FAIL wd_counters: got df=%0d so=%0d, required df=3 so=0", dropped_frames, sync_overruns);
    end
    check_drained("watchdog");
  endtask

  task automatic test_reset_mid_sync();
    do_reset();
    go_disp();
    src_rddata = {32'h0, 32'h0, 32'h0000_7000};
    launch_ch(3'b001, "rs_launch");
    pulse_finish(3'b001);
    sync_q.push_back(3'b001);
    pulse_vbs();
    tick(1);
    rst = 1'b1;
    #1;
    tests_run++;
    if ({sync_active, dma_start, ch_sync, dma_rdy_irq, dma_timeout_irq} !== '0 ||
        dma_src_addr !== '0 || dropped_frames !== '0) begin
      fails++;
      $display("FAIL midsync_reset: got sa=%b cs=%b addr=%h df=%0d, required all 0",
               sync_active, ch_sync, dma_src_addr, dropped_frames);
    end
    tick(1);
    rst = 1'b0;
    ch_sync_done = 3'b111;
    dma_finish   = 3'b111;
    tick(1);
    ch_sync_done = '0;
    dma_finish   = '0;
    tick(2);
    go_disp();
    pulse_vbs();
    tests_run++;
    if (dropped_frames !== 4'd1 || sync_active !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_nothing_ready: got df=%0d sa=%b, required df=1 sa=0", dropped_frames, sync_active);
    end
    tick(1);
    check_drained("reset_mid_sync");
  endtask

  initial begin
    rst              = 1'b1;
    vblank_start     = 1'b0;
    vblank_end_soon  = 1'b0;
    rowram_swap      = 1'b1;
    src_rddata       = '0;
    src_update_avail = '0;
    dma_finish       = '0;
    ch_sync_done     = '0;
    test_reset();
    test_launch();
    test_sync();
    test_overrun();
    test_dropped();
    test_watchdog();
    test_reset_mid_sync();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
